// File: rtl/spi_sclk_ctrl.sv
// spi_sclk_ctrl: SPI master SCLK / chip-select / strobe sequencer.
// Optional abort input enabled by defining SPI_SCLK_CTRL_ABORT_EN.
module spi_sclk_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk_in,
    input  logic             rstn,
`ifdef SPI_SCLK_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             busy,
    output logic             done,
    output logic             cs_n,
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] hcnt_q;
    logic [DIV_W-1:0] div_m1_q;
    logic [CNT_W-1:0] nbits_q;
    logic [CNT_W:0]   edge_q;
    logic             cpol_q;
    logic             cpha_q;
    logic             busy_q;
    logic             done_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             sample_q;
    logic             shift_q;

    logic [DIV_W-1:0] div_m1_d;
    logic [DIV_W-1:0] hcnt_dec;
    logic [CNT_W:0]   edge_d;
    logic             tick;
    logic             last_edge;
    logic             leading;
    logic             abort_hit;

`ifdef SPI_SCLK_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Half-period reload value, tick detect and edge bookkeeping
    always_comb begin
        div_m1_d  = (div == '0) ? '0 : div - DIV_W'(1);
        hcnt_dec  = hcnt_q - DIV_W'(1);
        tick      = (hcnt_q == '0);
        edge_d    = edge_q + {{CNT_W{1'b0}}, 1'b1};
        last_edge = (edge_d == {nbits_q, 1'b0});
        leading   = edge_d[0];
    end

    // Transfer sequencer with registered outputs
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            hcnt_q   <= '0;
            div_m1_q <= '0;
            nbits_q  <= '0;
            edge_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            if (abort_hit && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cs_n_q  <= 1'b1;
                sclk_q  <= cpol_q;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        sclk_q <= cpol;
                        if (start && nbits != '0) begin
                            state_q  <= S_SETUP;
                            busy_q   <= 1'b1;
                            cs_n_q   <= 1'b0;
                            div_m1_q <= div_m1_d;
                            hcnt_q   <= div_m1_d;
                            nbits_q  <= nbits;
                            cpol_q   <= cpol;
                            cpha_q   <= cpha;
                        end
                    end
                    S_SETUP: begin
                        if (tick) begin
                            state_q <= S_RUN;
                            hcnt_q  <= div_m1_q;
                            edge_q  <= '0;
                        end else begin
                            hcnt_q <= hcnt_dec;
                        end
                    end
                    S_RUN: begin
                        if (tick) begin
                            hcnt_q <= div_m1_q;
                            sclk_q <= ~sclk_q;
                            edge_q <= edge_d;
                            if (leading) begin
                                sample_q <= ~cpha_q;
                                shift_q  <= cpha_q;
                            end else begin
                                sample_q <= cpha_q;
                                shift_q  <= ~cpha_q & ~last_edge;
                            end
                            if (last_edge) begin
                                state_q <= S_HOLD;
                            end
                        end else begin
                            hcnt_q <= hcnt_dec;
                        end
                    end
                    S_HOLD: begin
                        if (tick) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            hcnt_q <= hcnt_dec;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;

endmodule
